inc_dec_counter: RTL

Parametrised registered up/down counter built on the library's carry-lookahead incrementer-decrementer. It adds programmable modulus, wrap or saturate overflow handling, synchronous clear/load, and registered carry/borrow and sticky-overflow flags. It is the sequential companion of the combinational arithmetic units, used for address generators, loop counters and credit counters.

---
 rtl/lau_pkg.sv | 17 +
 rtl/IncDecC.sv | 56 +++++
 rtl/behavioural_inc_dec_counter.sv | 62 ++++++
 rtl/inc_dec_counter.sv | 103 ++++++++++
 4 files changed

// File: rtl/lau_pkg.sv
// lau_pkg: shared types for the arithmetic unit library.
//   speed_e    : performance selector for the arithmetic units.
//                SLOW = ripple carry chain, FAST = parallel lookahead.
//   ovf_mode_e : counter overflow handling, decoded from the SAT pin.
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } ovf_mode_e;

endpackage

// File: rtl/IncDecC.sv
// IncDecC: combinational incrementer/decrementer.
//   z_o = a_i + ci_i when dec_i = 0, a_i - ci_i when dec_i = 1.
//   co_o is the carry-out (increment) or borrow-out (decrement).
// Ports:
//   a_i   [width-1:0] operand
//   ci_i              step enable (carry/borrow in)
//   dec_i             direction, 1 = decrement
//   z_o   [width-1:0] result
//   co_o              carry/borrow out
// Bit i toggles when ci_i is set and every lower bit is 1 (increment)
// or 0 (decrement). With speed = FAST each toggle term is formed
// directly from the operand bits (lookahead). With SLOW it ripples.
module IncDecC
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] a_i,
  input  logic             ci_i,
  input  logic             dec_i,
  output logic [width-1:0] z_o,
  output logic             co_o
);

  // Per-bit "propagate": bit value that lets a carry/borrow pass through.
  logic [width-1:0] prop;
  // toggle[i] = ci_i & prop[0] & ... & prop[i-1]; toggle[width] is carry-out.
  logic [width:0]   toggle;

  assign prop = dec_i ? ~a_i : a_i;

  if (speed == FAST) begin : g_fast
    always_comb begin
      toggle = '0;
      for (int i = 0; i <= width; i++) begin
        toggle[i] = ci_i;
        for (int j = 0; j < i; j++) begin
          toggle[i] = toggle[i] & prop[j];
        end
      end
    end
  end else begin : g_slow
    always_comb begin
      toggle    = '0;
      toggle[0] = ci_i;
      for (int i = 1; i <= width; i++) begin
        toggle[i] = toggle[i-1] & prop[i-1];
      end
    end
  end

  assign z_o  = a_i ^ toggle[width-1:0];
  assign co_o = toggle[width];

endmodule

// File: rtl/behavioural_inc_dec_counter.sv
// behavioural_inc_dec_counter: reference model of inc_dec_counter using
// plain +/- arithmetic, same ports and parameters, for equivalence checks.
module behavioural_inc_dec_counter
  import lau_pkg::*;
#(
  parameter int               width  = 8,
  parameter speed_e           speed  = FAST,
  parameter logic [width-1:0] RESVAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic             DEC,
  input  logic             SAT,
  input  logic [width-1:0] LIM,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             ST
);

  localparam speed_e SpeedUnused = speed;

  logic [width-1:0] q_q;
  logic             co_q, st_q;

  assign TC = DEC ? (q_q == '0) : (q_q >= LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= RESVAL;
      co_q <= 1'b0;
      st_q <= 1'b0;
    end else if (CLR) begin
      q_q  <= '0;
      co_q <= 1'b0;
      st_q <= 1'b0;
    end else if (LD) begin
      q_q  <= D;
      co_q <= 1'b0;
      st_q <= 1'b0;
    end else if (EN && !TC) begin
      q_q  <= DEC ? q_q - 1'b1 : q_q + 1'b1;
      co_q <= 1'b0;
    end else if (EN) begin
      if (SAT) q_q <= DEC ? '0 : LIM;
      else     q_q <= DEC ? LIM : '0;
      co_q <= 1'b1;
      st_q <= 1'b1;
    end else begin
      co_q <= 1'b0;
    end
  end

  assign Q  = q_q;
  assign CO = co_q;
  assign ST = st_q;

endmodule

// File: rtl/inc_dec_counter.sv
// inc_dec_counter: registered up/down counter with range 0..LIM.
// Ports:
//   clk_i, rst_ni   clock (rising edge), async active-low reset
//   CLR             synchronous clear (highest priority)
//   LD, D           synchronous load of D (no clamping to LIM)
//   EN              count enable, one step per cycle
//   DEC             0 = up, 1 = down
//   SAT             0 = wrap, 1 = saturate at the range ends
//   LIM             upper bound of the count range
//   Q               counter value (registered)
//   TC              terminal count, combinational from Q/LIM/DEC
//   CO              registered carry/borrow pulse, one cycle per overflow
//   ST              sticky overflow, cleared by CLR or LD
// Priority per cycle: CLR > LD > EN > hold.
module inc_dec_counter
  import lau_pkg::*;
#(
  parameter int               width  = 8,
  parameter speed_e           speed  = FAST,
  parameter logic [width-1:0] RESVAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic             DEC,
  input  logic             SAT,
  input  logic [width-1:0] LIM,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             ST
);

  logic [width-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             st_q, st_d;
  logic [width-1:0] step_z;
  logic             step_co_unused;
  ovf_mode_e        mode;

  assign mode = ovf_mode_e'(SAT);

  // Step unit; its carry-out is not used, overflow is decided by TC alone
  // so that the programmable LIM behaves identically to LIM = all ones.
  IncDecC #(
    .width(width),
    .speed(speed)
  ) u_step (
    .a_i  (q_q),
    .ci_i (EN),
    .dec_i(DEC),
    .z_o  (step_z),
    .co_o (step_co_unused)
  );

  // Q >= LIM (not ==) so an out-of-range loaded value still terminates up.
  assign TC = DEC ? (q_q == '0) : (q_q >= LIM);

  always_comb begin
    q_d  = q_q;
    co_d = 1'b0;
    st_d = st_q;
    if (CLR) begin
      q_d  = '0;
      st_d = 1'b0;
    end else if (LD) begin
      q_d  = D;
      st_d = 1'b0;
    end else if (EN) begin
      if (!TC) begin
        q_d = step_z;
      end else begin
        co_d = 1'b1;
        st_d = 1'b1;
        if (mode == WRAP) begin
          q_d = DEC ? LIM : '0;
        end else begin
          q_d = DEC ? '0 : LIM;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= RESVAL;
      co_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
      st_q <= st_d;
    end
  end

  assign Q  = q_q;
  assign CO = co_q;
  assign ST = st_q;

endmodule
